// File: rtl/norm_window_buffer.sv
// Sliding window of the last DEPTH normalized frames. Each time a new frame
// completes a full window, the window is streamed out word by word, oldest frame first.
module norm_window_buffer #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_norm [0:N_CH-1],
    input  logic                       i_clear,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_last,
    output logic [$clog2(DEPTH+1)-1:0] o_fill,
    output logic                       o_drop
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_FRM = PTR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(DEPTH);

    typedef enum logic {S_FILL, S_STREAM} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mem [0:DEPTH-1][0:N_CH-1];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [FILL_W-1:0]  r_fill;
    logic [PTR_W-1:0]   r_rd_frm;
    logic [CH_W-1:0]    r_rd_ch;
    logic [PTR_W-1:0]   r_sent;
    logic               r_drop;

    logic               w_accept;
    logic               w_xfer;
    logic               w_last_ch;
    logic               w_win_full;
    logic [PTR_W-1:0]   w_wr_ptr_inc;
    logic [PTR_W-1:0]   w_rd_frm_inc;
    logic [FILL_W-1:0]  w_fill_nxt;

    // Frames are only captured while filling; a clear swallows a coincident frame.
    assign w_accept     = (r_state == S_FILL) && i_valid && !i_clear;
    assign w_xfer       = o_valid && i_ready;
    assign w_last_ch    = (r_rd_ch == LAST_CH);
    assign w_wr_ptr_inc = (r_wr_ptr == LAST_FRM) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_frm_inc = (r_rd_frm == LAST_FRM) ? '0 : r_rd_frm + 1'b1;
    assign w_fill_nxt   = (r_fill == FULL) ? FULL : r_fill + 1'b1;
    assign w_win_full   = (w_fill_nxt == FULL);

    assign o_valid = (r_state == S_STREAM);
    assign o_last  = o_valid && w_last_ch && (r_sent == LAST_FRM);
    assign o_data  = o_valid ? r_mem[r_rd_frm][r_rd_ch] : '0;
    assign o_fill  = r_fill;
    assign o_drop  = r_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_FILL;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL:   if (w_accept && w_win_full) w_state_nxt = S_STREAM;
                S_STREAM: if (w_xfer && o_last)       w_state_nxt = S_FILL;
                default:  w_state_nxt = S_FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_rd_frm <= '0;
            r_rd_ch  <= '0;
            r_sent   <= '0;
            r_drop   <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_rd_frm <= '0;
            r_rd_ch  <= '0;
            r_sent   <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= i_valid && (r_state == S_STREAM);
            if (w_accept) begin
                r_wr_ptr <= w_wr_ptr_inc;
                r_fill   <= w_fill_nxt;
                // Once full, the slot after the newest frame holds the oldest one.
                if (w_win_full) begin
                    r_rd_frm <= w_wr_ptr_inc;
                    r_rd_ch  <= '0;
                    r_sent   <= '0;
                end
            end
            if (w_xfer) begin
                if (w_last_ch) begin
                    r_rd_ch  <= '0;
                    r_rd_frm <= w_rd_frm_inc;
                    r_sent   <= r_sent + 1'b1;
                end else begin
                    r_rd_ch  <= r_rd_ch + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int c = 0; c < N_CH; c++) r_mem[r_wr_ptr][c] <= i_norm[c];
        end
    end

endmodule

// File: tb/tb_norm_window_buffer.sv
// Randomized self-checking bench for norm_window_buffer against a queue model
// holding the most recent DEPTH frames as a flat word list.
module tb_norm_window_buffer;
    localparam int N_CH  = 8;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int FULL_W = DEPTH * N_CH;

    typedef logic [WIDTH-1:0] frame_t [N_CH];

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic [WIDTH-1:0] norm [0:N_CH-1];
    logic             clear;
    logic             ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic [$clog2(DEPTH+1)-1:0] o_fill;
    logic             o_drop;

    int n_chk  = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] hist [$];
    frame_t dropfr;

    norm_window_buffer #(.N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_norm(norm),
        .i_clear(clear), .i_ready(ready), .o_valid(o_valid), .o_data(o_data),
        .o_last(o_last), .o_fill(o_fill), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t mkf(input int f);
        frame_t fr;
        for (int c = 0; c < N_CH; c++) fr[c] = WIDTH'(16'h0100 * f + c);
        return fr;
    endfunction

    function automatic frame_t rndf();
        frame_t fr;
        for (int c = 0; c < N_CH; c++) fr[c] = WIDTH'($urandom);
        return fr;
    endfunction

    function automatic int model_fill();
        return hist.size() / N_CH;
    endfunction

    // Only called while the block is filling, so the frame is always accepted.
    task automatic send_frame(input frame_t fr);
        norm  = fr;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 0; c < N_CH; c++) hist.push_back(fr[c]);
        while (hist.size() > FULL_W) void'(hist.pop_front());
        chk("strobe_valid", o_valid, hist.size() == FULL_W);
        chk("strobe_fill", o_fill, model_fill());
        chk("strobe_nodrop", o_drop, 0);
    endtask

    // bp: 0 ready high, 1 pattern 1,0,0, 2 random. drop_at: cycle to inject dropfr.
    task automatic drain(input int bp, input int drop_at);
        logic [WIDTH-1:0] exp [$];
        int idx = 0;
        int cyc = 0;
        logic hv = 1'b0;
        logic [WIDTH-1:0] held = '0;
        logic hl = 1'b0;
        exp = hist;
        while (idx < exp.size() && cyc < 400) begin
            if (bp == 0)      ready = 1'b1;
            else if (bp == 1) ready = (cyc % 3 == 0);
            else              ready = 1'($urandom_range(0, 1));
            chk("stream_valid", o_valid, 1);
            if (hv) begin
                chk("hold_data", o_data, held);
                chk("hold_last", o_last, hl);
            end
            chk("data", o_data, exp[idx]);
            chk("last", o_last, idx == exp.size() - 1);
            hv = !ready; held = o_data; hl = o_last;
            if (ready) idx++;
            if (cyc == drop_at) begin
                norm  = dropfr;
                valid = 1'b1;
            end
            step();
            valid = 1'b0;
            chk("drop", o_drop, cyc == drop_at);
            cyc++;
        end
        ready = 1'b1;
        if (idx < exp.size()) chk("drain_timeout", idx, exp.size());
        chk("idle_after", o_valid, 0);
        chk("fill_after", o_fill, model_fill());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_fill"}, o_fill, 0);
        chk({tag, "_drop"}, o_drop, 0);
    endtask

    initial begin
        frame_t sfr;
        rst_n = 1'b0; valid = 1'b0; clear = 1'b0; ready = 1'b1;
        norm = mkf(0);
        step(); step();
        check_zero("reset");
        rst_n = 1'b1;
        step();

        // Fill and stream frames 1..4
        for (int f = 1; f <= DEPTH; f++) send_frame(mkf(f));
        drain(0, -1);

        // Slide with frame 5; frame 6 arrives mid-stream and is dropped
        dropfr = mkf(6);
        send_frame(mkf(5));
        drain(0, 5);
        send_frame(mkf(7));
        drain(0, -1);

        // Backpressure on a fresh window
        clear = 1'b1; step(); clear = 1'b0;
        hist.delete();
        chk("clear_fill", o_fill, 0);
        for (int f = 1; f <= DEPTH; f++) send_frame(mkf(f));
        drain(1, -1);

        // Sign-extreme values pass through untouched
        for (int c = 0; c < N_CH; c++)
            sfr[c] = (c % 3 == 0) ? 16'hFF80 : (c % 3 == 1) ? 16'h8000 : 16'h7FFF;
        send_frame(sfr);
        drain(1, -1);

        // Clear mid-stream with a coincident frame
        send_frame(mkf(9));
        step(); step();
        clear = 1'b1; valid = 1'b1; norm = mkf(10);
        step();
        clear = 1'b0; valid = 1'b0;
        hist.delete();
        chk("clr_valid", o_valid, 0);
        chk("clr_fill", o_fill, 0);
        chk("clr_nodrop", o_drop, 0);
        step();
        chk("clr_nodrop2", o_drop, 0);
        for (int f = 11; f <= 10 + DEPTH; f++) send_frame(mkf(f));
        drain(0, -1);

        // Async reset mid-stream
        send_frame(mkf(20));
        step(); step();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        step();
        rst_n = 1'b1;
        hist.delete();
        step();
        check_zero("post_rst");

        // Random frames, random backpressure, occasional drops
        for (int i = 0; i < 24; i++) begin
            send_frame(rndf());
            if (hist.size() == FULL_W) begin
                dropfr = rndf();
                drain(2, int'($urandom_range(0, 40)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
